// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen : prescaled Fibonacci LFSR bit source with seed load and lockup guard
// Optional macro LFSR_STEP_CNT_EN adds a 16-bit step counter output.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
    parameter int               DIV          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic             lfsr,
    output logic             lfsr_valid,
    output logic [WIDTH-1:0] lfsr_state,
    output logic             lockup
`ifdef LFSR_STEP_CNT_EN
    ,
    output logic [15:0]      step_cnt
`endif
);

    localparam int              c_CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_HOLD  = 2'd0;
    localparam logic [1:0] c_ST_COUNT = 2'd1;
    localparam logic [1:0] c_ST_STEP  = 2'd2;
    localparam logic [1:0] c_ST_LOAD  = 2'd3;

    logic [WIDTH-1:0]   r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_lockup;

    logic [1:0]         w_mode;
    logic               w_fb;
    logic [WIDTH-1:0]   w_next;
    logic               w_seed_zero;
    logic [WIDTH-1:0]   w_load_val;

    assign w_fb        = ^(r_state & TAPS);
    assign w_next      = {r_state[WIDTH-2:0], w_fb};
    assign w_seed_zero = (seed == '0);
    // An all-zero seed would freeze the register forever, so substitute the default.
    assign w_load_val  = w_seed_zero ? SEED_DEFAULT : seed;

    // Operating mode is re-derived every cycle; load outranks everything.
    always_comb begin
        w_mode = c_ST_HOLD;
        if (seed_load) begin
            w_mode = c_ST_LOAD;
        end else if (en) begin
            w_mode = (r_cnt == c_CNT_LAST) ? c_ST_STEP : c_ST_COUNT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= SEED_DEFAULT;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
            unique case (w_mode)
                c_ST_LOAD: begin
                    r_state  <= w_load_val;
                    r_cnt    <= '0;
                    r_lockup <= w_seed_zero;
                end
                c_ST_STEP: begin
                    r_state <= w_next;
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                end
                c_ST_COUNT: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

`ifdef LFSR_STEP_CNT_EN
    logic [15:0] r_step_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_cnt <= '0;
        end else if (w_mode == c_ST_LOAD) begin
            r_step_cnt <= '0;
        end else if (w_mode == c_ST_STEP) begin
            r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    assign step_cnt = r_step_cnt;
`endif

    assign lfsr_state = r_state;
    assign lfsr       = r_state[WIDTH-1];
    assign lfsr_valid = r_valid;
    assign lockup     = r_lockup;

endmodule

`default_nettype wire

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Pseudo-random bit source that drives the single-bit `lfsr` input of the downstream 3-state control FSM (inputs `start`/`lfsr`).
- Fibonacci LFSR advanced at a prescaled rate.
- Supports seed loading, all-zero lockup protection and a one-cycle strobe per new bit.
- Sits between top-level control (enable/seed) and the FSM.

Parameters:
- WIDTH, 16, LFSR register width (>=4).
- TAPS, 16'hB400, feedback mask; bit i set means state[i] is XORed into the feedback.
- SEED_DEFAULT, 16'hACE1, reset value and substitute for an all-zero seed; must be non-zero.
- DIV, 4, clock cycles per LFSR step (>=1). DIV=1 steps every enabled cycle.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable; steps occur only while high.
- seed_load  input  1  single-cycle request to load `seed`.
- seed  input  WIDTH  seed value, sampled when seed_load=1.
- lfsr  output  1  current pseudo-random bit = lfsr_state[WIDTH-1]; feeds the FSM.
- lfsr_valid  output  1  one-cycle strobe: a new lfsr value is visible this cycle.
- lfsr_state  output  WIDTH  full LFSR register.
- lockup  output  1  one-cycle pulse: an all-zero seed was replaced by SEED_DEFAULT.

Behaviour:
- Reset (reset=0, async):
  - lfsr_state=SEED_DEFAULT, prescaler cnt=0.
  - lfsr_valid=0, lockup=0.
  - lfsr=SEED_DEFAULT[WIDTH-1].
- Step function:
  - fb = XOR over i of (state[i] & TAPS[i]).
  - next = {state[WIDTH-2:0], fb}.
  - All registers update on posedge clk.
- Prescaler:
  - While en=1 and no seed_load: cnt counts 0..DIV-1.
  - On the edge where cnt==DIV-1: the state steps, cnt wraps to 0, and lfsr_valid=1 for the following cycle (the first cycle the new state is visible). Otherwise lfsr_valid=0.
  - First step occurs on the DIV-th enabled edge after en rises from cnt=0.
- en=0:
  - State holds, cnt clears to 0, lfsr_valid=0.
  - Re-enable restarts a full DIV-cycle interval.
- seed_load=1 (priority over stepping, regardless of en):
  - lfsr_state <= seed, or SEED_DEFAULT if seed==0.
  - cnt <= 0, lfsr_valid <= 0.
  - lockup <= (seed==0) for exactly one cycle.
- seed_load held several cycles:
  - Reloads every cycle; no steps occur.
  - lockup pulses each cycle while seed==0.
- Zero state is unreachable: reset and load both guarantee a non-zero state, and the step function preserves non-zero for any TAPS with bit WIDTH-1 set.
- Reset asserted mid-operation: immediate return to the reset values; any pending step is lost.
- Internal states:
  - HOLD (en=0).
  - COUNT (en=1, cnt<DIV-1).
  - STEP (en=1, cnt==DIV-1).
  - LOAD (seed_load=1; highest priority).
  - Transitions are evaluated every cycle from the inputs and cnt.

Optional Feature:
- Macro: LFSR_STEP_CNT_EN.
- Defined: adds output `step_cnt` [15:0].
  - Increments (wrapping 16'hFFFF->0) on every step.
  - Clears to 0 on reset and on seed_load.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then hold en=0 for 10 cycles -> lfsr_state=16'hACE1, lfsr=1, lfsr_valid=0, lockup=0 throughout.
- en=1 from cycle 0, DIV=4 -> first lfsr_valid in cycle 4 with lfsr_state=16'h59C3, lfsr=0; second lfsr_valid in cycle 8 with 16'hB387, lfsr=1; no strobes in between.
- seed_load=1, seed=16'h0001 while en=1 mid-count -> next cycle lfsr_state=16'h0001, lfsr_valid=0, lockup=0; next step arrives DIV cycles after the load.
- seed_load=1, seed=0 -> lfsr_state=16'hACE1, lockup=1 for exactly one cycle; lfsr_state never 0 over 100 subsequent steps.
- Drop en after 2 enabled cycles, re-raise after 5 -> state unchanged while low; first strobe exactly 4 cycles after re-enable.
- Assert reset for 1 cycle mid-run with LFSR_STEP_CNT_EN defined -> all outputs return to reset values asynchronously, step_cnt=0; after 3 steps, step_cnt=3.
